// File: rtl/vote_button_array.sv
// vote_button_array
// Debounce and vote qualifier for the ballot-unit push buttons. Each raw button
// must be seen high on HOLD_CYCLES consecutive edges before it can produce a vote.
// Every press yields at most one registered single-cycle pulse. After an accepted
// vote or a rejected simultaneous press, all channels are locked out for
// LOCKOUT_CYCLES. A saturating tally counts the accepted votes.
//
// Ports
//   clock       rising-edge clock
//   reset       synchronous, active-high
//   button      synchronised raw buttons, 1 = pressed
//   vote_en     1 = voting open; 0 = hold counters cleared, nothing accepted
//   valid_vote  one-hot single-cycle pulse on the accepted channel
//   vote_valid  OR of valid_vote
//   vote_id     index of the accepted channel while vote_valid is high, else 0
//   conflict    single-cycle pulse when a simultaneous qualification is rejected
//   busy        lockout active
//   vote_total  accepted-vote count, saturates at all-ones
module vote_button_array #(
  parameter int N_BUTTONS      = 4,
  parameter int HOLD_CYCLES    = 2,
  parameter int CNT_W          = 32,
  parameter int LOCKOUT_CYCLES = 4,
  parameter int MULTI_REJECT   = 1,
  parameter int TOTAL_W        = 16,
  localparam int ID_W          = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] button,
  input  logic                 vote_en,
  output logic [N_BUTTONS-1:0] valid_vote,
  output logic                 vote_valid,
  output logic [ID_W-1:0]      vote_id,
  output logic                 conflict,
  output logic                 busy,
  output logic [TOTAL_W-1:0]   vote_total
);

  localparam int LOCK_W = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;

  logic [CNT_W-1:0]     hold_cnt [N_BUTTONS];
  logic [LOCK_W-1:0]    lock_cnt;
  logic [N_BUTTONS-1:0] qual;
  logic [N_BUTTONS-1:0] winner;
  logic [ID_W-1:0]      winner_id;
  logic                 found;
  logic                 any_qual;
  logic                 multi_qual;
  logic                 accept;
  logic                 reject;

  // A channel qualifies only on the edge its counter steps from HOLD-1 to HOLD.
  // A counter already saturated at HOLD can never qualify again, which is what
  // limits each press to a single vote and drops presses that mature in lockout.
  always_comb begin
    qual      = '0;
    winner    = '0;
    winner_id = '0;
    found     = 1'b0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      qual[i] = vote_en & button[i] & (hold_cnt[i] == CNT_W'(HOLD_CYCLES - 1)) &
                (lock_cnt == '0);
    end
    for (int i = 0; i < N_BUTTONS; i++) begin
      if (qual[i] && !found) begin
        winner[i] = 1'b1;
        winner_id = ID_W'(i);
        found     = 1'b1;
      end
    end
    any_qual   = |qual;
    // More than one bit set: clearing the lowest set bit leaves something behind.
    multi_qual = (qual & (qual - N_BUTTONS'(1))) != '0;
    reject     = multi_qual && (MULTI_REJECT != 0);
    accept     = any_qual && !reject;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_BUTTONS; i++) hold_cnt[i] <= '0;
      lock_cnt   <= '0;
      valid_vote <= '0;
      vote_valid <= 1'b0;
      vote_id    <= '0;
      conflict   <= 1'b0;
      vote_total <= '0;
    end else begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        if (!vote_en || !button[i])
          hold_cnt[i] <= '0;
        else if (hold_cnt[i] < CNT_W'(HOLD_CYCLES))
          hold_cnt[i] <= hold_cnt[i] + CNT_W'(1);
      end

      valid_vote <= accept ? winner : '0;
      vote_valid <= accept;
      vote_id    <= accept ? winner_id : '0;
      conflict   <= reject;

      // Lockout is a down-counter loaded on the same edge that issues the pulse.
      if (accept || reject)
        lock_cnt <= LOCK_W'(LOCKOUT_CYCLES);
      else if (lock_cnt != '0)
        lock_cnt <= lock_cnt - LOCK_W'(1);

      if (accept && (vote_total != '1))
        vote_total <= vote_total + TOTAL_W'(1);
    end
  end

  assign busy = (lock_cnt != '0);

endmodule
